// File: rtl/red_pitaya_na_accumulator.sv
// Network-analyzer averaging engine: after a start pulse, waits a settling
// time, then sums CHANNELS signed sample streams over a fixed number of valid
// samples, saturating each sum and latching the results for readout.
module red_pitaya_na_accumulator #(
    parameter int CHANNELS = 2,
    parameter int INBITS   = 24,
    parameter int SUMBITS  = 62,
    parameter int CNTBITS  = 32
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [CNTBITS-1:0]           sleep_cycles_i,
    input  logic [CNTBITS-1:0]           avg_cycles_i,
    input  logic [CHANNELS*INBITS-1:0]   dat_i,
    input  logic                         dat_valid_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         sum_valid_o,
    output logic [CHANNELS*SUMBITS-1:0]  sum_o,
    output logic [CHANNELS-1:0]          ovf_o,
    output logic [CNTBITS-1:0]           count_o
);

    typedef enum logic [1:0] {IDLE, SLEEP, ACCUM} state_t;

    localparam logic [SUMBITS-1:0] SUM_MAX = {1'b0, {(SUMBITS-1){1'b1}}};
    localparam logic [SUMBITS-1:0] SUM_MIN = {1'b1, {(SUMBITS-1){1'b0}}};

    state_t                            state;
    state_t                            state_nxt;
    logic [CNTBITS-1:0]                sleep_cnt;
    logic [CNTBITS-1:0]                avg_len;
    logic [CNTBITS-1:0]                count_inc;
    logic [CHANNELS-1:0][SUMBITS-1:0]  acc;
    logic [CHANNELS-1:0][SUMBITS-1:0]  acc_nxt;
    logic [CHANNELS-1:0][SUMBITS:0]    wide;
    logic [CHANNELS-1:0]               ovf_nxt;
    logic                              take;
    logic                              last;

    assign busy_o    = (state != IDLE);
    assign count_inc = count_o + 1'b1;

    // Saturating add of each sign-extended sample to its working sum
    always_comb begin
        wide    = '0;
        acc_nxt = '0;
        ovf_nxt = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            wide[k] = {acc[k][SUMBITS-1], acc[k]}
                    + {{(SUMBITS+1-INBITS){dat_i[k*INBITS+INBITS-1]}}, dat_i[k*INBITS +: INBITS]};
            if (wide[k][SUMBITS] != wide[k][SUMBITS-1]) begin
                ovf_nxt[k] = 1'b1;
                acc_nxt[k] = wide[k][SUMBITS] ? SUM_MIN : SUM_MAX;
            end else begin
                acc_nxt[k] = wide[k][SUMBITS-1:0];
            end
        end
    end

    // Next-state logic: abort beats start, start beats completion
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        last      = 1'b0;
        if (abort_i) begin
            state_nxt = IDLE;
        end else if (start_i) begin
            if (avg_cycles_i == '0)
                state_nxt = IDLE;
            else if (sleep_cycles_i != '0)
                state_nxt = SLEEP;
            else
                state_nxt = ACCUM;
        end else begin
            case (state)
                SLEEP: begin
                    if (sleep_cnt == CNTBITS'(1))
                        state_nxt = ACCUM;
                end
                ACCUM: begin
                    if (dat_valid_i) begin
                        take = 1'b1;
                        if (count_inc == avg_len) begin
                            last      = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Counters, working sums and latched results
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sleep_cnt   <= '0;
            avg_len     <= '0;
            acc         <= '0;
            count_o     <= '0;
            ovf_o       <= '0;
            sum_o       <= '0;
            sum_valid_o <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (!abort_i && start_i) begin
                sleep_cnt   <= sleep_cycles_i;
                avg_len     <= avg_cycles_i;
                acc         <= '0;
                count_o     <= '0;
                ovf_o       <= '0;
                sum_valid_o <= 1'b0;
                // Zero-length run completes immediately with an all-zero result
                if (avg_cycles_i == '0) begin
                    sum_o       <= '0;
                    sum_valid_o <= 1'b1;
                    done_o      <= 1'b1;
                end
            end else if (!abort_i) begin
                if (state == SLEEP)
                    sleep_cnt <= sleep_cnt - 1'b1;
                if (take) begin
                    acc     <= acc_nxt;
                    count_o <= count_inc;
                    ovf_o   <= ovf_o | ovf_nxt;
                end
                if (last) begin
                    sum_o       <= acc_nxt;
                    sum_valid_o <= 1'b1;
                    done_o      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_na_accumulator.sv
// Self-checking bench for red_pitaya_na_accumulator: a scoreboard of expected
// results is compared whenever done_o pulses; each task checks its own scenario.
module tb_red_pitaya_na_accumulator;

    localparam int CH   = 2;
    localparam int INB  = 24;
    localparam int SUMB = 62;
    localparam int SATB = 26;
    localparam int CNTB = 32;

    typedef struct {
        longint      s0;
        longint      s1;
        int unsigned cnt;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [CNTB-1:0]      sleep_cycles = '0;
    logic [CNTB-1:0]      avg_cycles = '0;
    logic [CH*INB-1:0]    dat = '0;
    logic                 dat_valid = 1'b0;

    logic                 busy, done, sum_valid;
    logic [CH*SUMB-1:0]   sum;
    logic [CH-1:0]        ovf;
    logic [CNTB-1:0]      count;

    logic                 sat_busy, sat_done, sat_sum_valid;
    logic [CH*SATB-1:0]   sat_sum;
    logic [CH-1:0]        sat_ovf;
    logic [CNTB-1:0]      sat_count;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    red_pitaya_na_accumulator #(.CHANNELS(CH), .INBITS(INB), .SUMBITS(SUMB), .CNTBITS(CNTB)) u_dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
        .sleep_cycles_i(sleep_cycles), .avg_cycles_i(avg_cycles),
        .dat_i(dat), .dat_valid_i(dat_valid),
        .busy_o(busy), .done_o(done), .sum_valid_o(sum_valid),
        .sum_o(sum), .ovf_o(ovf), .count_o(count)
    );

    red_pitaya_na_accumulator #(.CHANNELS(CH), .INBITS(INB), .SUMBITS(SATB), .CNTBITS(CNTB)) u_sat (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
        .sleep_cycles_i(sleep_cycles), .avg_cycles_i(avg_cycles),
        .dat_i(dat), .dat_valid_i(dat_valid),
        .busy_o(sat_busy), .done_o(sat_done), .sum_valid_o(sat_sum_valid),
        .sum_o(sat_sum), .ovf_o(sat_ovf), .count_o(sat_count)
    );

    always #5 clk = ~clk;

    // Scoreboard: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (done) begin
            exp_t   e;
            longint g0, g1;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected got=1 want=0 at %0t", $time);
            end else begin
                e  = sb.pop_front();
                g0 = longint'($signed(sum[SUMB-1:0]));
                g1 = longint'($signed(sum[2*SUMB-1:SUMB]));
                total += 3;
                if (g0 !== e.s0) begin
                    bad++;
                    $display("FAIL sb_sum0 got=%0d want=%0d", g0, e.s0);
                end
                if (g1 !== e.s1) begin
                    bad++;
                    $display("FAIL sb_sum1 got=%0d want=%0d", g1, e.s1);
                end
                if (count !== e.cnt) begin
                    bad++;
                    $display("FAIL sb_count got=%0d want=%0d", count, e.cnt);
                end
                if (sum_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL sb_sum_valid got=%0b want=1", sum_valid);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dat(input int c0, input int c1);
        dat = {c1[INB-1:0], c0[INB-1:0]};
    endtask

    task automatic check_all_zero(input string tag);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sum_valid !== 1'b0 || sum !== '0 ||
            ovf !== '0 || count !== '0) begin
            bad++;
            $display("FAIL %s got busy=%0b done=%0b sv=%0b sum=%0h ovf=%0b cnt=%0d want all 0",
                     tag, busy, done, sum_valid, sum, ovf, count);
        end
        total++;
        if (sat_sum !== '0 || sat_count !== '0 || sat_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_sat got sum=%0h cnt=%0d busy=%0b want 0", tag, sat_sum, sat_count, sat_busy);
        end
    endtask

    task automatic test_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int n;
        sleep_cycles = 0; avg_cycles = 4; dat_valid = 1'b1;
        set_dat(100, -3);
        sb.push_back('{s0: 400, s1: -12, cnt: 4});
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b want=1", busy); end
        while (!done && n < 50) begin step(); n++; end
        total++;
        if (n !== 5) begin bad++; $display("FAIL basic_latency got=%0d want=5", n); end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_pulse got done=%0b busy=%0b want 0 0", done, busy);
        end
    endtask

    task automatic test_sleep();
        int n, v, busyc;
        sleep_cycles = 3; avg_cycles = 2; dat_valid = 1'b1;
        v = 1;
        set_dat(v, 0);
        sb.push_back('{s0: 11, s1: 0, cnt: 2});
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        busyc = busy ? 1 : 0;
        while (!done && n < 50) begin
            v++;
            set_dat(v, 0);
            step();
            n++;
            if (busy) busyc++;
        end
        total += 2;
        if (n !== 6) begin bad++; $display("FAIL sleep_latency got=%0d want=6", n); end
        if (busyc !== 5) begin bad++; $display("FAIL sleep_busy_clks got=%0d want=5", busyc); end
        step();
    endtask

    task automatic test_valid_gap();
        sleep_cycles = 0; avg_cycles = 3; dat_valid = 1'b1;
        set_dat(999, 999);
        sb.push_back('{s0: 90, s1: -9, cnt: 3});
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dat_valid = (i % 2 == 0);
            set_dat(10 * (i + 1), -(i + 1));
            step();
            if (i == 3) begin
                total++;
                if (count !== 2 || busy !== 1'b1) begin
                    bad++; $display("FAIL gap_hold got cnt=%0d busy=%0b want 2 1", count, busy);
                end
            end
        end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL gap_done got=%0b want=1", done); end
        dat_valid = 1'b1;
        step();
    endtask

    task automatic test_saturation();
        longint m, ms, smax;
        int     n;
        logic   sat_flag;
        smax = (longint'(1) <<< (SATB - 1)) - 1;
        m = 0; ms = 0; sat_flag = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m  += 8388607;
            ms += 8388607;
            if (ms > smax) begin ms = smax; sat_flag = 1'b1; end
        end
        sleep_cycles = 0; avg_cycles = 16; dat_valid = 1'b1;
        set_dat(8388607, -5);
        sb.push_back('{s0: m, s1: -80, cnt: 16});
        start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!done && n < 50) begin step(); n++; end
        total += 4;
        if (n !== 17) begin bad++; $display("FAIL sat_latency got=%0d want=17", n); end
        if (longint'($signed(sat_sum[SATB-1:0])) !== ms) begin
            bad++; $display("FAIL sat_sum0 got=%0d want=%0d", $signed(sat_sum[SATB-1:0]), ms);
        end
        if (longint'($signed(sat_sum[2*SATB-1:SATB])) !== -80) begin
            bad++; $display("FAIL sat_sum1 got=%0d want=-80", $signed(sat_sum[2*SATB-1:SATB]));
        end
        if (sat_ovf !== {1'b0, sat_flag} || ovf !== 2'b00) begin
            bad++; $display("FAIL sat_ovf got sat=%0b main=%0b want sat=0%0b main=00", sat_ovf, ovf, sat_flag);
        end
        step();
    endtask

    task automatic test_restart_abort();
        sleep_cycles = 0; avg_cycles = 8; dat_valid = 1'b1;
        set_dat(7, 7);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (count !== 0 || sum_valid !== 1'b0) begin
            bad++; $display("FAIL restart_clear got cnt=%0d sv=%0b want 0 0", count, sum_valid);
        end
        repeat (3) step();
        total++;
        if (count !== 3 || busy !== 1'b1) begin
            bad++; $display("FAIL restart_count got cnt=%0d busy=%0b want 3 1", count, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();
        total += 3;
        if (busy !== 1'b0 || sum_valid !== 1'b0 || count !== 3) begin
            bad++; $display("FAIL abort_state got busy=%0b sv=%0b cnt=%0d want 0 0 3", busy, sum_valid, count);
        end
        if (longint'($signed(sum[SUMB-1:0])) !== 64'sd134217712) begin
            bad++; $display("FAIL abort_sum_hold got=%0d want=134217712", $signed(sum[SUMB-1:0]));
        end
        if (ovf !== 2'b00) begin bad++; $display("FAIL abort_ovf got=%0b want=00", ovf); end
    endtask

    task automatic test_back_to_back();
        sleep_cycles = 0; avg_cycles = 2; dat_valid = 1'b1;
        set_dat(5, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        set_dat(6, 2);
        avg_cycles = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (done !== 1'b0 || count !== 0) begin
            bad++; $display("FAIL b2b_collide got done=%0b cnt=%0d want 0 0", done, count);
        end
        set_dat(9, -4);
        sb.push_back('{s0: 9, s1: -4, cnt: 1});
        step();
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%0b want=1", done); end
        step();
    endtask

    task automatic test_async_reset();
        sleep_cycles = 0; avg_cycles = 8; dat_valid = 1'b1;
        set_dat(3, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        #3;
        rstn = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rstn = 1'b1;
        step();
        avg_cycles = 0;
        sb.push_back('{s0: 0, s1: 0, cnt: 0});
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (done !== 1'b1 || sum_valid !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL avg0_done got done=%0b sv=%0b busy=%0b want 1 1 0", done, sum_valid, busy);
        end
        step();
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL avg0_pulse got=%0b want=0", done); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sleep();
        test_valid_gap();
        test_saturation();
        test_restart_abort();
        test_back_to_back();
        test_async_reset();
        repeat (3) step();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_pending got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
